// File: rtl/spectro_pkg.sv
// rtl/spectro_pkg.sv - shared types and constants for the spectrogram front end
package spectro_pkg;

   typedef enum logic [2:0] {
      IDLE,
      QUAL,
      PULSE,
      DEAD,
      WAIT_LOW
   } ch_state_e;

   localparam int DROP_W       = 8;
   localparam int N_CH_DEFAULT = 15;

   // Bits needed to hold values 0..max_val.
   function automatic int unsigned cnt_w(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/impulse_channel.sv
// rtl/impulse_channel.sv - one channel: synchroniser, glitch qualifier, pulse and refractory FSM
module impulse_channel
   import spectro_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int MIN_HIGH    = 2,
   parameter int PULSE_LEN   = 4,
   parameter int DEAD_CYCLES = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic ch_in,
   input  logic hold,
   output logic pulse,
   output logic drop_strobe
);

   localparam int QW = cnt_w(MIN_HIGH);
   localparam int DW = cnt_w(DEAD_CYCLES);
   localparam int FW = cnt_w(SYNC_STAGES);
   localparam logic [QW-1:0] QUAL_MAX   = QW'(MIN_HIGH);
   localparam logic [DW-1:0] DEAD_LOAD  = DW'(DEAD_CYCLES);
   localparam logic [DW-1:0] PULSE_LAST = DW'(DEAD_CYCLES - PULSE_LEN + 1);
   localparam logic [DW-1:0] DEAD_ONE   = DW'(1);
   localparam logic [FW-1:0] FILL_MAX   = FW'(SYNC_STAGES);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [FW-1:0]          fill_q, fill_d;
   logic                   armed_q, armed_d;
   ch_state_e              state_q, state_d;
   logic [QW-1:0]          qual_q, qual_d, qual_nxt;
   logic [DW-1:0]          dead_q, dead_d;
   logic                   pulse_q, pulse_d;
   logic                   s, s_valid, qualify;

   assign s        = sync_q[SYNC_STAGES-1];
   assign s_valid  = (fill_q == FILL_MAX);
   assign qual_nxt = qual_q + 1'b1;

   // After reset the channel must see a genuine low on its input before it
   // can arm, so a level still high across reset never yields a pulse.
   always_comb begin
      sync_d      = {sync_q[SYNC_STAGES-2:0], ch_in};
      fill_d      = s_valid ? fill_q : fill_q + 1'b1;
      armed_d     = armed_q | (s_valid & ~s);
      state_d     = state_q;
      qual_d      = qual_q;
      dead_d      = (dead_q != '0) ? dead_q - 1'b1 : dead_q;
      qualify     = 1'b0;

      case (state_q)
         IDLE: begin
            if (s_valid && armed_q && s) begin
               if (MIN_HIGH == 1) begin
                  qualify = 1'b1;
               end else begin
                  state_d = QUAL;
                  qual_d  = QW'(1);
               end
            end
         end
         QUAL: begin
            if (!s) begin
               state_d = IDLE;
            end else if (qual_nxt == QUAL_MAX) begin
               qualify = 1'b1;
            end else begin
               qual_d = qual_nxt;
            end
         end
         PULSE: begin
            if (dead_q == PULSE_LAST) begin
               state_d = (dead_q <= DEAD_ONE) ? WAIT_LOW : DEAD;
            end
         end
         DEAD: begin
            if (dead_q <= DEAD_ONE) begin
               state_d = WAIT_LOW;
            end
         end
         WAIT_LOW: begin
            if (s_valid && !s) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (qualify) begin
         state_d = hold ? DEAD : PULSE;
         dead_d  = DEAD_LOAD;
      end

      pulse_d     = (state_d == PULSE);
      drop_strobe = qualify & hold;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q  <= '0;
         fill_q  <= '0;
         armed_q <= 1'b0;
         state_q <= IDLE;
         qual_q  <= '0;
         dead_q  <= '0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         fill_q  <= fill_d;
         armed_q <= armed_d;
         state_q <= state_d;
         qual_q  <= qual_d;
         dead_q  <= dead_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/impulse_conditioner.sv
// rtl/impulse_conditioner.sv - conditions comparator outputs into clean per-channel count pulses
module impulse_conditioner
   import spectro_pkg::*;
#(
   parameter int N_CH        = N_CH_DEFAULT,
   parameter int SYNC_STAGES = 2,
   parameter int MIN_HIGH    = 2,
   parameter int PULSE_LEN   = 4,
   parameter int DEAD_CYCLES = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_CH-1:0]   ch_in,
   input  logic              hold,
   output logic [N_CH-1:0]   ch_out,
   output logic              event_any,
   output logic [DROP_W-1:0] drop_cnt
);

   localparam int PW = cnt_w(N_CH);
   localparam int SW = DROP_W + PW;
   localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

   logic [N_CH-1:0]   pulse, drop_strobe;
   logic [PW-1:0]     drop_num;
   logic [SW-1:0]     drop_sum;
   logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
   logic              event_any_q, event_any_d;

   for (genvar i = 0; i < N_CH; i++) begin : gen_ch
      impulse_channel #(
         .SYNC_STAGES (SYNC_STAGES),
         .MIN_HIGH    (MIN_HIGH),
         .PULSE_LEN   (PULSE_LEN),
         .DEAD_CYCLES (DEAD_CYCLES)
      ) u_ch (
         .clk         (clk),
         .reset       (reset),
         .ch_in       (ch_in[i]),
         .hold        (hold),
         .pulse       (pulse[i]),
         .drop_strobe (drop_strobe[i])
      );
   end

   // Several channels may drop on the same cycle; add them all at once.
   always_comb begin
      drop_num = '0;
      for (int i = 0; i < N_CH; i++) begin
         drop_num = drop_num + PW'(drop_strobe[i]);
      end
      drop_sum    = SW'(drop_cnt_q) + SW'(drop_num);
      drop_cnt_d  = (drop_sum > SW'(DROP_MAX)) ? DROP_MAX : drop_sum[DROP_W-1:0];
      event_any_d = |pulse;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         drop_cnt_q  <= '0;
         event_any_q <= 1'b0;
      end else begin
         drop_cnt_q  <= drop_cnt_d;
         event_any_q <= event_any_d;
      end
   end

   assign ch_out    = pulse;
   assign event_any = event_any_q;
   assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_impulse_conditioner.sv
// tb/tb_impulse_conditioner.sv - self-checking bench for impulse_conditioner
module tb_impulse_conditioner;

   localparam int N_CH        = 15;
   localparam int MIN_HIGH    = 2;
   localparam int PULSE_LEN   = 4;
   localparam int DEAD_CYCLES = 8;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            hold = 1'b0;
   logic [N_CH-1:0] ch_in = '0;
   logic [N_CH-1:0] ch_out;
   logic            event_any;
   logic [7:0]      drop_cnt;

   int checks = 0;
   int errors = 0;

   impulse_conditioner #(
      .N_CH        (N_CH),
      .SYNC_STAGES (2),
      .MIN_HIGH    (MIN_HIGH),
      .PULSE_LEN   (PULSE_LEN),
      .DEAD_CYCLES (DEAD_CYCLES)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ch_in     (ch_in),
      .hold      (hold),
      .ch_out    (ch_out),
      .event_any (event_any),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   // Reference: per channel, a run length of high samples, an ignore deadline
   // after each event, a need-low flag, and the edge where its pulse ends.
   int              cyc = 0;
   int              run [N_CH];
   int              busy_until [N_CH];
   int              pulse_until [N_CH];
   bit              need_low [N_CH];
   logic [N_CH-1:0] s0 = '0, s1 = '0, m_next;
   bit              v0 = 0, v1 = 0;
   logic [N_CH-1:0] m_out = '0;
   bit              m_any = 0;
   int              m_drop = 0;
   int              m_drops;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (reset) begin
         for (int i = 0; i < N_CH; i++) begin
            run[i] = 0;
            need_low[i] = 1;
            busy_until[i] = cyc;
            pulse_until[i] = -1;
         end
         v0 = 0; v1 = 0; s0 = '0; s1 = '0;
         m_out = '0; m_any = 0; m_drop = 0;
      end else begin
         m_drops = 0;
         for (int i = 0; i < N_CH; i++) begin
            if (v1 && cyc > busy_until[i]) begin
               if (need_low[i]) begin
                  if (!s1[i]) need_low[i] = 0;
                  run[i] = 0;
               end else if (s1[i]) begin
                  run[i] = run[i] + 1;
                  if (run[i] == MIN_HIGH) begin
                     busy_until[i] = cyc + DEAD_CYCLES;
                     need_low[i] = 1;
                     run[i] = 0;
                     if (hold) m_drops = m_drops + 1;
                     else pulse_until[i] = cyc + PULSE_LEN - 1;
                  end
               end else begin
                  run[i] = 0;
               end
            end
            m_next[i] = (cyc <= pulse_until[i]);
         end
         m_any = |m_out;
         m_out = m_next;
         m_drop = (m_drop + m_drops > 255) ? 255 : m_drop + m_drops;
         s1 = s0; v1 = v0; s0 = ch_in; v0 = 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic apply_reset();
      reset = 1'b1; ch_in = '0; hold = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; hold = 1'b1; ch_in = '1;
      repeat (4) tick();
      checks++;
      if (ch_out !== '0) begin errors++; $display("FAIL reset_ch_out got %h want 0", ch_out); end
      checks++;
      if (event_any !== 1'b0) begin errors++; $display("FAIL reset_event_any got %b want 0", event_any); end
      checks++;
      if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
      apply_reset();
   endtask

   task automatic test_single_event();
      int  pulses = 0;
      bit  prev = 0;
      bit  exp_o, exp_a;
      ch_in[0] = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (k == 10) ch_in[0] = 1'b0;
         exp_o = (k >= 4 && k <= 7);
         exp_a = (k >= 5 && k <= 8);
         checks++;
         if (ch_out[0] !== exp_o) begin errors++; $display("FAIL single_ch_out edge %0d got %b want %b", k, ch_out[0], exp_o); end
         checks++;
         if (event_any !== exp_a) begin errors++; $display("FAIL single_event_any edge %0d got %b want %b", k, event_any, exp_a); end
         checks++;
         if ({ch_out, event_any, drop_cnt} !== {m_out, m_any, 8'(m_drop)}) begin
            errors++; $display("FAIL single_model edge %0d got %h/%b/%0d want %h/%b/%0d", k, ch_out, event_any, drop_cnt, m_out, m_any, m_drop);
         end
         if (ch_out[0] && !prev) pulses++;
         prev = ch_out[0];
      end
      checks++;
      if (pulses !== 1) begin errors++; $display("FAIL single_pulse_count got %0d want 1", pulses); end
   endtask

   task automatic test_glitch();
      int high_cycles = 0;
      ch_in[3] = 1'b1;
      tick();
      ch_in[3] = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         checks++;
         if (ch_out !== '0 || ch_out !== m_out) begin errors++; $display("FAIL glitch_1cyc got %h want 0", ch_out); end
      end
      ch_in[3] = 1'b1;
      repeat (2) tick();
      ch_in[3] = 1'b0;
      for (int k = 3; k <= 16; k++) begin
         tick();
         if (ch_out[3]) high_cycles++;
         checks++;
         if ({ch_out, event_any} !== {m_out, m_any}) begin errors++; $display("FAIL glitch_2cyc_model edge %0d got %h want %h", k, ch_out, m_out); end
      end
      checks++;
      if (high_cycles !== PULSE_LEN) begin errors++; $display("FAIL glitch_2cyc_width got %0d want %0d", high_cycles, PULSE_LEN); end
   endtask

   task automatic test_refractory();
      int last = -1000;
      int pulses = 0;
      bit prev = 0;
      ch_in[5] = 1'b1;
      for (int k = 1; k <= 90; k++) begin
         tick();
         if (k % 3 == 0) ch_in[5] = ~ch_in[5];
         checks++;
         if ({ch_out, event_any} !== {m_out, m_any}) begin errors++; $display("FAIL refractory_model edge %0d got %h want %h", k, ch_out, m_out); end
         if (ch_out[5] && !prev) begin
            if (pulses > 0) begin
               checks++;
               if (k - last < DEAD_CYCLES + 1 + MIN_HIGH) begin errors++; $display("FAIL refractory_gap got %0d want >= %0d", k - last, DEAD_CYCLES + 1 + MIN_HIGH); end
            end
            pulses++;
            last = k;
         end
         prev = ch_out[5];
      end
      checks++;
      if (pulses < 5) begin errors++; $display("FAIL refractory_pulses got %0d want >= 5", pulses); end
      ch_in[5] = 1'b0;
      repeat (14) tick();
   endtask

   task automatic test_hold_drop();
      bit [7:0] exp_d;
      apply_reset();
      hold = 1'b1;
      ch_in[2:0] = 3'b111;
      for (int k = 1; k <= 6; k++) begin
         tick();
         exp_d = (k >= 4) ? 8'd3 : 8'd0;
         checks++;
         if (drop_cnt !== exp_d) begin errors++; $display("FAIL hold_drop3 edge %0d got %0d want %0d", k, drop_cnt, exp_d); end
         checks++;
         if (ch_out !== '0) begin errors++; $display("FAIL hold_no_pulse edge %0d got %h want 0", k, ch_out); end
      end
      ch_in = '0;
      for (int k = 0; k < 420; k++) begin
         tick();
         ch_in = (k % 12 < 3) ? '1 : '0;
         checks++;
         if ({ch_out, drop_cnt} !== {m_out, 8'(m_drop)}) begin errors++; $display("FAIL hold_sat_model cycle %0d got %h/%0d want %h/%0d", k, ch_out, drop_cnt, m_out, m_drop); end
      end
      checks++;
      if (drop_cnt !== 8'd255) begin errors++; $display("FAIL hold_saturate got %0d want 255", drop_cnt); end
      ch_in = '0; hold = 1'b0;
      repeat (14) tick();
   endtask

   task automatic test_hold_mid_pulse();
      bit exp_o;
      apply_reset();
      ch_in[7] = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 4) hold = 1'b1;
         exp_o = (k >= 4 && k <= 7);
         checks++;
         if (ch_out[7] !== exp_o) begin errors++; $display("FAIL midhold_ch_out edge %0d got %b want %b", k, ch_out[7], exp_o); end
         checks++;
         if (drop_cnt !== 8'd0) begin errors++; $display("FAIL midhold_drop edge %0d got %0d want 0", k, drop_cnt); end
      end
      hold = 1'b0; ch_in = '0;
      repeat (6) tick();
   endtask

   task automatic test_reset_mid_pulse();
      bit exp_o;
      ch_in[9] = 1'b1;
      repeat (5) tick();
      checks++;
      if (ch_out[9] !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b want 1", ch_out[9]); end
      reset = 1'b1;
      tick();
      checks++;
      if ({ch_out, event_any} !== '0) begin errors++; $display("FAIL rstmid_clear got %h/%b want 0", ch_out, event_any); end
      reset = 1'b0;
      for (int k = 0; k < 18; k++) begin
         tick();
         if (k == 15) ch_in[9] = 1'b0;
         checks++;
         if (ch_out !== '0 || ch_out !== m_out) begin errors++; $display("FAIL rstmid_no_pulse cycle %0d got %h want 0", k, ch_out); end
      end
      ch_in[9] = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         tick();
         exp_o = (k >= 4 && k <= 7);
         checks++;
         if (ch_out[9] !== exp_o || ch_out !== m_out) begin errors++; $display("FAIL rstmid_rearm edge %0d got %b want %b", k, ch_out[9], exp_o); end
      end
      ch_in = '0;
      repeat (12) tick();
   endtask

   task automatic test_random();
      logic [N_CH-1:0] flip;
      apply_reset();
      for (int k = 0; k < 1500; k++) begin
         flip = '0;
         for (int i = 0; i < N_CH; i++) flip[i] = ($urandom_range(0, 3) == 0);
         ch_in = ch_in ^ flip;
         if ($urandom_range(0, 9) == 0) hold = ~hold;
         reset = ($urandom_range(0, 299) == 0);
         tick();
         checks++;
         if ({ch_out, event_any, drop_cnt} !== {m_out, m_any, 8'(m_drop)}) begin
            errors++; $display("FAIL random_model cycle %0d got %h/%b/%0d want %h/%b/%0d", k, ch_out, event_any, drop_cnt, m_out, m_any, m_drop);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single_event();
      test_glitch();
      test_refractory();
      test_hold_drop();
      test_hold_mid_pulse();
      test_reset_mid_pulse();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
